ram_reader: RTL and testbench

Autonomous read-side controller for the 32x4 single-port synchronous RAM used in the lab designs. It sweeps every address in order, accounts for the RAM's read latency, holds each word for a programmable dwell time, and presents address/data pairs to the hex-display path. Writes from the switch interface are arbitrated onto the same RAM port and take priority over scanning, so one RAM instance serves both the writer and the reader.

---
 rtl/ram_reader_pkg.sv | 25 ++
 rtl/ram_reader_dwell_counter.sv | 36 +++
 rtl/ram_reader.sv | 198 +++++++++++++++++++
 tb/tb_ram_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// ram_reader_pkg
//   Shared definitions for the RAM scan/display controller:
//   - state_t   : controller states (idle, issue, wait, dwell, write)
//   - DEF_*     : default RAM geometry (32 x 4)
//   - cnt_width : width of a down-counter able to hold values 0..max_count-1
package ram_reader_pkg;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 4;

    // The S_ prefix keeps the dwell state distinct from the DWELL parameter
    // of ram_reader.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DWELL,
        S_WRITE
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/ram_reader_dwell_counter.sv
// dwell_counter
//   Loadable down-counter used by ram_reader for both the read-latency wait
//   and the per-word dwell. A phase lasting N cycles is obtained by loading
//   N-1; expired is high on the last cycle of the phase.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   load         : load load_val (takes priority over hold)
//   load_val     : value to load
//   hold         : freeze the count (used while a write pre-empts a dwell)
//   expired      : count has reached zero
module dwell_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         expired
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (!hold && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/ram_reader.sv
// ram_reader
//   Read-side controller for a single-port synchronous RAM. Sweeps every
//   address in order, waits out the RAM read latency, holds each word on the
//   display outputs for DWELL cycles, and arbitrates single-cycle writes from
//   the switch interface onto the same RAM port (writes take priority).
// Parameters: ADDR_W, DATA_W, RD_LAT (>=1), DWELL (>=1)
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   enable                : scan enable; low parks the sweep in idle
//   wr_req/wr_addr/wr_data: single-cycle write strobe and its payload
//   ram_address/ram_data/ram_wren : registered RAM port drive
//   ram_q                 : RAM read data
//   disp_addr/disp_data   : last captured address/word
//   disp_valid            : set once the first word has been captured
//   wr_busy               : high during the RAM write cycle
// Optional build macro RAM_READER_CHECKSUM_EN adds sweep_sum/sweep_done:
//   XOR of all words captured in one full sweep, loaded with a one-cycle
//   sweep_done pulse when the last address is captured.
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned DWELL  = 50_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wr_busy
`ifdef RAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] sweep_sum,
    output logic              sweep_done
`endif
);

    localparam int unsigned CNT_MAX = (DWELL > RD_LAT) ? DWELL : RD_LAT;
    localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    state_t            dwell_exit;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_hold;
    logic              cnt_expired;
    logic              capture;

    assign cnt_hold = (state_q == S_WRITE);

    dwell_counter #(
        .W (CNT_W)
    ) u_dwell_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .hold     (cnt_hold),
        .expired  (cnt_expired)
    );

    // A write arriving on the final dwell cycle still consumes that cycle:
    // the pointer advances now and the write returns straight to the
    // post-dwell state, so the dwell grows by exactly the write cycle.
    always_comb begin
        state_d      = state_q;
        resume_d     = resume_q;
        ptr_d        = ptr_q;
        cnt_load     = 1'b0;
        cnt_load_val = WAIT_LOAD;
        capture      = 1'b0;
        dwell_exit   = enable ? S_ISSUE : S_IDLE;

        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    state_d  = S_WRITE;
                    resume_d = S_IDLE;
                end else if (enable) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_req) begin
                    state_d  = S_WRITE;
                    resume_d = S_ISSUE;
                end else begin
                    state_d      = S_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (wr_req) begin
                    state_d  = S_WRITE;
                    resume_d = S_ISSUE;
                end else if (cnt_expired) begin
                    capture      = 1'b1;
                    state_d      = S_DWELL;
                    cnt_load     = 1'b1;
                    cnt_load_val = DWELL_LOAD;
                end
            end
            S_DWELL: begin
                if (cnt_expired) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (wr_req) begin
                        state_d  = S_WRITE;
                        resume_d = dwell_exit;
                    end else begin
                        state_d = dwell_exit;
                    end
                end else if (wr_req) begin
                    state_d  = S_WRITE;
                    resume_d = S_DWELL;
                end
            end
            S_WRITE: begin
                state_d = resume_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // RAM port and display outputs are registered from the next state so
    // that each output is valid during the cycle its state is occupied.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            resume_q    <= S_IDLE;
            ptr_q       <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            wr_busy     <= 1'b0;
            disp_addr   <= '0;
            disp_data   <= '0;
            disp_valid  <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            ptr_q    <= ptr_d;
            ram_wren <= (state_d == S_WRITE);
            wr_busy  <= (state_d == S_WRITE);
            if (state_d == S_WRITE) begin
                ram_address <= wr_addr;
                ram_data    <= wr_data;
            end else if (state_d == S_ISSUE) begin
                ram_address <= ptr_d;
            end
            if (capture) begin
                disp_addr  <= ptr_q;
                disp_data  <= ram_q;
                disp_valid <= 1'b1;
            end
        end
    end

`ifdef RAM_READER_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            sweep_sum  <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            if (capture) begin
                if (ptr_q == '1) begin
                    sweep_sum  <= acc_q ^ ram_q;
                    sweep_done <= 1'b1;
                    acc_q      <= '0;
                end else begin
                    acc_q <= acc_q ^ ram_q;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader
//   Directed bench for ram_reader with RD_LAT=1, DWELL=4 (6-cycle period)
//   against a behavioural 32x4 synchronous RAM (old-data read).
//   Checksum scenario is compiled when RAM_READER_CHECKSUM_EN is defined.
module tb_ram_reader;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       wr_req;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic [4:0] ram_address;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic [3:0] ram_q;
    logic [4:0] disp_addr;
    logic [3:0] disp_data;
    logic       disp_valid;
    logic       wr_busy;
`ifdef RAM_READER_CHECKSUM_EN
    logic [3:0] sweep_sum;
    logic       sweep_done;
`endif

    int vectors;
    int errors;

    ram_reader #(
        .ADDR_W (5),
        .DATA_W (4),
        .RD_LAT (1),
        .DWELL  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .wr_busy     (wr_busy)
`ifdef RAM_READER_CHECKSUM_EN
        ,
        .sweep_sum   (sweep_sum),
        .sweep_done  (sweep_done)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [3:0] mem [0:31];
    always @(posedge clock) begin
        if (ram_wren) mem[ram_address] <= ram_data;
        ram_q <= mem[ram_address];
    end

    function automatic logic [3:0] pat(input logic [4:0] a);
        return a[3:0] ^ 4'hA;
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        step(1);
        wr_req = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        enable  = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        step(2);
        vectors++; if (ram_address !== 5'd0) begin errors++; $display("FAIL reset_ram_address got=%0h exp=0", ram_address); end
        vectors++; if (ram_data !== 4'd0) begin errors++; $display("FAIL reset_ram_data got=%0h exp=0", ram_data); end
        vectors++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren got=%0b exp=0", ram_wren); end
        vectors++; if (disp_addr !== 5'd0) begin errors++; $display("FAIL reset_disp_addr got=%0h exp=0", disp_addr); end
        vectors++; if (disp_data !== 4'd0) begin errors++; $display("FAIL reset_disp_data got=%0h exp=0", disp_data); end
        vectors++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid got=%0b exp=0", disp_valid); end
        vectors++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL reset_wr_busy got=%0b exp=0", wr_busy); end
`ifdef RAM_READER_CHECKSUM_EN
        vectors++; if (sweep_sum !== 4'd0) begin errors++; $display("FAIL reset_sweep_sum got=%0h exp=0", sweep_sum); end
        vectors++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done got=%0b exp=0", sweep_done); end
`endif
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_preload;
        logic [4:0] a;
        for (int n = 0; n < 32; n++) begin
            a       = 5'(n);
            wr_req  = 1'b1;
            wr_addr = a;
            wr_data = pat(a);
            step(1);
            wr_req = 1'b0;
            vectors++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL wr_wren_high a=%0d got=%0b exp=1", n, ram_wren); end
            vectors++; if (wr_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_high a=%0d got=%0b exp=1", n, wr_busy); end
            vectors++; if (ram_address !== a) begin errors++; $display("FAIL wr_address a=%0d got=%0h exp=%0h", n, ram_address, a); end
            vectors++; if (ram_data !== pat(a)) begin errors++; $display("FAIL wr_data a=%0d got=%0h exp=%0h", n, ram_data, pat(a)); end
            step(1);
            vectors++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wr_wren_low a=%0d got=%0b exp=0", n, ram_wren); end
            vectors++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_low a=%0d got=%0b exp=0", n, wr_busy); end
        end
    endtask

    // Full sweep with wrap; ends just after the second capture of address 0.
    task automatic test_sweep;
        logic [4:0] a;
        logic [4:0] prev;
        enable = 1'b1;
        step(1);
        vectors++; if (ram_address !== 5'd0) begin errors++; $display("FAIL sweep_issue_addr got=%0h exp=0", ram_address); end
        step(1);
        vectors++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL sweep_valid_early got=%0b exp=0", disp_valid); end
        step(1);
        vectors++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid got=%0b exp=1", disp_valid); end
        vectors++; if (disp_addr !== 5'd0) begin errors++; $display("FAIL sweep_first_addr got=%0h exp=0", disp_addr); end
        vectors++; if (disp_data !== 4'hA) begin errors++; $display("FAIL sweep_first_data got=%0h exp=a", disp_data); end
        for (int n = 1; n <= 32; n++) begin
            a    = 5'(n);
            prev = 5'(n - 1);
            step(5);
            vectors++; if (disp_addr !== prev) begin errors++; $display("FAIL sweep_hold n=%0d got=%0h exp=%0h", n, disp_addr, prev); end
            step(1);
            vectors++; if (disp_addr !== a) begin errors++; $display("FAIL sweep_addr n=%0d got=%0h exp=%0h", n, disp_addr, a); end
            vectors++; if (disp_data !== pat(a)) begin errors++; $display("FAIL sweep_data n=%0d got=%0h exp=%0h", n, disp_data, pat(a)); end
        end
        vectors++; if (pat(5'd5) !== 4'hF) begin errors++; $display("FAIL pattern_addr5 got=%0h exp=f", pat(5'd5)); end
    endtask

    // Starts 1 cycle after capture of address 0; WAIT for address 3 is 17 cycles later.
    task automatic test_write_in_wait;
        step(17);
        wr_req  = 1'b1;
        wr_addr = 5'd3;
        wr_data = 4'h7;
        step(1);
        wr_req = 1'b0;
        vectors++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL wait_wr_wren got=%0b exp=1", ram_wren); end
        vectors++; if (ram_address !== 5'd3) begin errors++; $display("FAIL wait_wr_addr got=%0h exp=3", ram_address); end
        vectors++; if (ram_data !== 4'h7) begin errors++; $display("FAIL wait_wr_data got=%0h exp=7", ram_data); end
        vectors++; if (disp_addr !== 5'd2) begin errors++; $display("FAIL wait_no_capture got=%0h exp=2", disp_addr); end
        step(1);
        vectors++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wait_wren_pulse got=%0b exp=0", ram_wren); end
        vectors++; if (ram_address !== 5'd3) begin errors++; $display("FAIL wait_reissue_addr got=%0h exp=3", ram_address); end
        step(1);
        vectors++; if (disp_addr !== 5'd2) begin errors++; $display("FAIL wait_restart_hold got=%0h exp=2", disp_addr); end
        step(1);
        vectors++; if (disp_addr !== 5'd3) begin errors++; $display("FAIL wait_capture_addr got=%0h exp=3", disp_addr); end
        vectors++; if (disp_data !== 4'h7) begin errors++; $display("FAIL wait_capture_data got=%0h exp=7", disp_data); end
    endtask

    // Starts 1 cycle after capture of address 3 (first dwell cycle).
    task automatic test_write_in_dwell;
        step(1);
        wr_req  = 1'b1;
        wr_addr = 5'd20;
        wr_data = 4'h5;
        step(1);
        wr_req = 1'b0;
        vectors++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL dwell_wr_wren got=%0b exp=1", ram_wren); end
        vectors++; if (disp_addr !== 5'd3) begin errors++; $display("FAIL dwell_disp_addr got=%0h exp=3", disp_addr); end
        step(4);
        vectors++; if (disp_addr !== 5'd3) begin errors++; $display("FAIL dwell_extended_addr got=%0h exp=3", disp_addr); end
        vectors++; if (disp_data !== 4'h7) begin errors++; $display("FAIL dwell_extended_data got=%0h exp=7", disp_data); end
        step(1);
        vectors++; if (disp_addr !== 5'd4) begin errors++; $display("FAIL dwell_next_addr got=%0h exp=4", disp_addr); end
        vectors++; if (disp_data !== 4'hE) begin errors++; $display("FAIL dwell_next_data got=%0h exp=e", disp_data); end
    endtask

    // Starts 1 cycle after capture of address 4; WAIT for address 9 is 29 cycles later.
    task automatic test_enable_drop;
        step(29);
        enable = 1'b0;
        step(1);
        vectors++; if (disp_addr !== 5'd9) begin errors++; $display("FAIL en_capture_addr got=%0h exp=9", disp_addr); end
        vectors++; if (disp_data !== 4'h3) begin errors++; $display("FAIL en_capture_data got=%0h exp=3", disp_data); end
        step(24);
        vectors++; if (disp_addr !== 5'd9) begin errors++; $display("FAIL en_parked_addr got=%0h exp=9", disp_addr); end
        vectors++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL en_parked_valid got=%0b exp=1", disp_valid); end
        enable = 1'b1;
        step(1);
        vectors++; if (ram_address !== 5'd10) begin errors++; $display("FAIL en_resume_issue got=%0h exp=a", ram_address); end
        step(2);
        vectors++; if (disp_addr !== 5'd10) begin errors++; $display("FAIL en_resume_addr got=%0h exp=a", disp_addr); end
        vectors++; if (disp_data !== 4'h0) begin errors++; $display("FAIL en_resume_data got=%0h exp=0", disp_data); end
    endtask

    task automatic test_reset_in_write;
        wr_req  = 1'b1;
        wr_addr = 5'd1;
        wr_data = 4'h9;
        step(1);
        wr_req = 1'b0;
        vectors++; if (ram_wren !== 1'b1) begin errors++; $display("FAIL rst_wr_wren_high got=%0b exp=1", ram_wren); end
        reset = 1'b1;
        #1;
        vectors++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren_async got=%0b exp=0", ram_wren); end
        vectors++; if (ram_address !== 5'd0) begin errors++; $display("FAIL rst_ram_address got=%0h exp=0", ram_address); end
        vectors++; if (ram_data !== 4'd0) begin errors++; $display("FAIL rst_ram_data got=%0h exp=0", ram_data); end
        vectors++; if (disp_addr !== 5'd0) begin errors++; $display("FAIL rst_disp_addr got=%0h exp=0", disp_addr); end
        vectors++; if (disp_data !== 4'd0) begin errors++; $display("FAIL rst_disp_data got=%0h exp=0", disp_data); end
        vectors++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp_valid got=%0b exp=0", disp_valid); end
        vectors++; if (wr_busy !== 1'b0) begin errors++; $display("FAIL rst_wr_busy got=%0b exp=0", wr_busy); end
        step(1);
        reset = 1'b0;
        step(3);
        vectors++; if (disp_addr !== 5'd0) begin errors++; $display("FAIL rst_restart_addr got=%0h exp=0", disp_addr); end
        vectors++; if (disp_data !== 4'hA) begin errors++; $display("FAIL rst_restart_data got=%0h exp=a", disp_data); end
        step(6);
        vectors++; if (disp_addr !== 5'd1) begin errors++; $display("FAIL rst_aborted_addr got=%0h exp=1", disp_addr); end
        vectors++; if (disp_data !== 4'hB) begin errors++; $display("FAIL rst_aborted_data got=%0h exp=b", disp_data); end
    endtask

`ifdef RAM_READER_CHECKSUM_EN
    task automatic test_checksum;
        logic found;
        reset  = 1'b1;
        enable = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);
        for (int n = 0; n < 32; n++) do_write(5'(n), 4'h1);
        enable = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            if (sweep_done === 1'b1) found = 1'b1;
        end
        vectors++; if (!found) begin errors++; $display("FAIL cks_done1 got=timeout exp=pulse"); end
        vectors++; if (sweep_sum !== 4'h0) begin errors++; $display("FAIL cks_sum1 got=%0h exp=0", sweep_sum); end
        vectors++; if (disp_addr !== 5'd31) begin errors++; $display("FAIL cks_done_addr got=%0h exp=1f", disp_addr); end
        step(1);
        vectors++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL cks_pulse_width got=%0b exp=0", sweep_done); end
        do_write(5'd7, 4'h3);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            if (sweep_done === 1'b1) found = 1'b1;
        end
        vectors++; if (!found) begin errors++; $display("FAIL cks_done2 got=timeout exp=pulse"); end
        vectors++; if (sweep_sum !== 4'h2) begin errors++; $display("FAIL cks_sum2 got=%0h exp=2", sweep_sum); end
    endtask
`endif

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_preload();
        test_sweep();
        test_write_in_wait();
        test_write_in_dwell();
        test_enable_drop();
        test_reset_in_write();
`ifdef RAM_READER_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
